// File: rtl/debounce_filter.sv
// Debounce filter: two-flop synchronizer followed by a persistence counter.
// out follows the synchronized input only after CYCLES consecutive mismatching samples.
module debounce_filter #(
  parameter int   CYCLES  = 4,
  parameter logic INITIAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic stable
);
  localparam int             CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          flip;

  // flip: the mismatch has now persisted for CYCLES samples, so out takes s2
  assign flip   = (s2 != out) && (cnt == LAST);
  assign stable = (s2 == out) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= INITIAL;
      s2   <= INITIAL;
      out  <= INITIAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      rise <= flip & s2;
      fall <= flip & ~s2;
      if (s2 == out || flip) cnt <= '0;
      else                   cnt <= cnt + CW'(1);
      if (flip) out <= s2;
    end
  end
endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: three instances covering CYCLES=4/INITIAL=1,
// CYCLES=4/INITIAL=0 and CYCLES=1/INITIAL=0 with hand-computed expectations.
module tb_debounce_filter;
  logic clk = 1'b0;
  logic rst_n;
  logic in_a, in_b, in_c;
  logic out_a, rise_a, fall_a, stable_a;
  logic out_b, rise_b, fall_b, stable_b;
  logic out_c, rise_c, fall_c, stable_c;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  debounce_filter #(.CYCLES(4), .INITIAL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .stable(stable_a));
  debounce_filter #(.CYCLES(4), .INITIAL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .stable(stable_b));
  debounce_filter #(.CYCLES(1), .INITIAL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in(in_c),
    .out(out_c), .rise(rise_c), .fall(fall_c), .stable(stable_c));

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hist [0:127];
    int nrise, nfall;
    logic exp_o, exp_r, exp_f;

    rst_n = 1'b0; in_a = 1'b0; in_b = 1'b1; in_c = 1'b1;
    #13;
    check("rst_out_a", out_a, 1'b1);
    check("rst_out_b", out_b, 1'b0);
    check("rst_out_c", out_c, 1'b0);
    check("rst_rise_b", rise_b, 1'b0);
    check("rst_fall_a", fall_a, 1'b0);
    check("rst_stable_a", stable_a, 1'b1);
    check("rst_stable_b", stable_b, 1'b1);

    // Release between edges; a: in=0 falls at edge 6, b: rises at edge 6, c: rises at edge 3
    @(posedge clk); #1; rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("a_out_e%0d", e),  out_a,  (e < 6) ? 1'b1 : 1'b0);
      check($sformatf("a_fall_e%0d", e), fall_a, (e == 6) ? 1'b1 : 1'b0);
      check($sformatf("a_rise_e%0d", e), rise_a, 1'b0);
      check($sformatf("b_out_e%0d", e),  out_b,  (e >= 6) ? 1'b1 : 1'b0);
      check($sformatf("b_rise_e%0d", e), rise_b, (e == 6) ? 1'b1 : 1'b0);
      check($sformatf("c_out_e%0d", e),  out_c,  (e >= 3) ? 1'b1 : 1'b0);
      check($sformatf("c_rise_e%0d", e), rise_c, (e == 3) ? 1'b1 : 1'b0);
      check($sformatf("c_fall_e%0d", e), fall_c, 1'b0);
    end
    check("a_stable_settled", stable_a, 1'b1);

    // Three-cycle high glitch on a (out=0): counter reaches 3 then clears, out holds
    in_a = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) in_a = 1'b0;
      tick();
      check($sformatf("glitch_out_e%0d", e),  out_a,  1'b0);
      check($sformatf("glitch_rise_e%0d", e), rise_a, 1'b0);
      if (e == 4) check("glitch_stable_mid", stable_a, 1'b0);
    end
    check("glitch_stable_end", stable_a, 1'b1);

    // Toggling every cycle never satisfies the persistence requirement
    for (int e = 0; e < 50; e++) begin
      in_a = e[0];
      tick();
      check($sformatf("toggle_out_e%0d", e),  out_a,  1'b0);
      check($sformatf("toggle_rise_e%0d", e), rise_a, 1'b0);
      check($sformatf("toggle_fall_e%0d", e), fall_a, 1'b0);
    end
    in_a = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    check("toggle_settled_out", out_a, 1'b0);

    // Square wave 10 low / 10 high: out is the input delayed by 6 edges
    nrise = 0; nfall = 0;
    for (int i = 0; i < 106; i++) begin
      hist[i] = (i < 100 && ((i / 10) % 2) == 1) ? 1 : 0;
      in_a = hist[i][0];
      tick();
      exp_o = (i >= 5) ? hist[i-5][0] : 1'b0;
      exp_r = (i >= 6) ? (hist[i-5] == 1 && hist[i-6] == 0) : 1'b0;
      exp_f = (i >= 6) ? (hist[i-5] == 0 && hist[i-6] == 1) : 1'b0;
      check($sformatf("sq_out_i%0d", i),  out_a,  exp_o);
      check($sformatf("sq_rise_i%0d", i), rise_a, exp_r);
      check($sformatf("sq_fall_i%0d", i), fall_a, exp_f);
      check($sformatf("sq_excl_i%0d", i), rise_a & fall_a, 1'b0);
      nrise += int'(rise_a);
      nfall += int'(fall_a);
    end
    checks++;
    assert (nrise === 5 && nfall === 5) else begin
      failures++;
      $error("FAIL sq_pulse_count observed=%0d/%0d expected=5/5", nrise, nfall);
    end

    // Reset mid-count on b discards the pending count
    rst_n = 1'b0; in_b = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    check("midrst_pre_out_b", out_b, 1'b0);
    check("midrst_pre_stable_b", stable_b, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_b", out_b, 1'b0);
    check("midrst_stable_b", stable_b, 1'b1);
    check("midrst_out_a", out_a, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rel_out_b_e%0d", e),  out_b,  (e >= 6) ? 1'b1 : 1'b0);
      check($sformatf("rel_rise_b_e%0d", e), rise_b, (e == 6) ? 1'b1 : 1'b0);
      check($sformatf("rel_fall_b_e%0d", e), fall_b, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 Parameter CYCLES, default 4: number of consecutive synchronized clock samples a new input level must persist before the output follows; legal range 1..65535.
REQ-002 Parameter INITIAL, default 0: 1-bit level loaded into the output and the synchronizer on reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  1  raw, possibly bouncing, asynchronous input level.
REQ-006 out  output  1  debounced level, registered.
REQ-007 rise  output  1  one-cycle pulse, registered, high in the cycle in which out goes 0->1.
REQ-008 fall  output  1  one-cycle pulse, registered, high in the cycle in which out goes 1->0.
REQ-009 stable  output  1  high when the synchronized input equals out and the counter is zero.

Function
REQ-010 The block SHALL pass in through a two-flop synchronizer (s1, s2) before any comparison.
REQ-011 The counter width SHALL be $clog2(CYCLES+1) bits; it SHALL never wrap.
REQ-012 On each edge with s2 == out, the counter SHALL clear to 0 and out SHALL hold.
REQ-013 On each edge with s2 != out and counter < CYCLES-1, the counter SHALL increment by 1 and out SHALL hold.
REQ-014 On each edge with s2 != out and counter == CYCLES-1, out SHALL take s2 and the counter SHALL clear to 0 in the same edge.
REQ-015 A level change on in, held steady, SHALL appear on out at the (CYCLES+2)-th rising edge after the first edge that samples it (2 synchronizer + CYCLES filter cycles).
REQ-016 Any excursion of s2 lasting fewer than CYCLES consecutive cycles SHALL NOT change out; a return of s2 to out SHALL restart the count from zero.
REQ-017 With CYCLES == 1, out SHALL follow s2 on the first mismatching edge (latency 3 edges).
REQ-018 rise/fall SHALL assert exactly on the edge where out changes and deassert on the next edge; they SHALL never be high simultaneously.
REQ-019 Continuous toggling of in with period shorter than CYCLES cycles SHALL leave out constant indefinitely.

Reset
REQ-020 While rst_n is low: s1, s2 and out SHALL equal INITIAL, counter 0, rise 0, fall 0, stable 1, independent of clk.
REQ-021 Reset asserted mid-count SHALL discard the pending count; after release, filtering restarts from INITIAL.
REQ-022 Release of rst_n SHALL not by itself generate a rise or fall pulse.

Verification
REQ-023 CYCLES=4, INITIAL=1, in=0 from reset release -> out stays 1 for edges 1-5, goes 0 at edge 6 with fall=1 for exactly that cycle.
REQ-024 CYCLES=4, in square wave 10 cycles low / 10 high for 100 cycles -> out is the same square wave delayed by 6 cycles; one rise and one fall per period.
REQ-025 CYCLES=4, out=0, in high for 3 cycles then low -> out stays 0, no rise pulse, counter back to 0.
REQ-026 CYCLES=4, in alternating every cycle for 50 cycles -> out constant, rise=fall=0 throughout.
REQ-027 CYCLES=1, INITIAL=0, in 0->1 -> out=1 on third edge with rise pulse.
REQ-028 rst_n pulsed low mid-count with INITIAL=0, in=1 -> out immediately 0; goes 1 at CYCLES+2 edges after release.
